mux4_arb_ctrl: RTL and testbench

MUX4_ARB_CTRL -- requirements
Module: mux4_arb_ctrl

---
 rtl/mux4_arb_pkg.sv | 18 +
 rtl/mux4_arb_ctrl_if.sv | 27 ++
 rtl/mux4_rr_pick.sv | 49 ++++
 rtl/mux4_arb_ctrl.sv | 103 ++++++++++
 tb/tb_mux4_arb_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared constants, FSM state encoding and grant decode for the 4-source mux arbiter.
package mux4_arb_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // One-hot grant vector for a select code.
    function automatic logic [NREQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        return NREQ'(1) << s;
    endfunction

endpackage

// File: rtl/mux4_arb_ctrl_if.sv
// Request/grant, mux control and captured-word handshake between the arbiter and its environment.
interface mux4_arb_ctrl_if #(
    parameter int unsigned DW = 4
);
    import mux4_arb_pkg::*;

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  gnt;
    logic [SEL_W-1:0] sel;
    logic             en;
    logic [DW-1:0]    mux_in;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;

    // master: the arbiter controller; slave: sources, mux and consumer.
    modport master (
        input  req, mux_in, out_ready,
        output gnt, sel, en, out_data, out_valid
    );

    modport slave (
        output req, mux_in, out_ready,
        input  gnt, sel, en, out_data, out_valid
    );

endinterface

// File: rtl/mux4_rr_pick.sv
// Combinational winner search: round-robin after last_winner, or fixed priority
// (req[0] highest) when MUX4_ARB_FIXED_PRIO_EN is defined.
module mux4_rr_pick
    import mux4_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] last_winner,
    output logic [SEL_W-1:0] win_idx,
    output logic             any_req
);

    logic             found;
    logic [SEL_W-1:0] idx;

    assign any_req = |req;

`ifdef MUX4_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last_winner;

    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = SEL_W'(k);
            if (!found && req[idx]) begin
                win_idx = idx;
                found   = 1'b1;
            end
        end
    end
`else
    // Offsets 1..NREQ wrap in SEL_W bits, so the previous winner is tried last.
    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = last_winner + SEL_W'(k);
            if (!found && req[idx]) begin
                win_idx = idx;
                found   = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/mux4_arb_ctrl.sv
// Arbitrates four sources onto a downstream 4:1 mux and captures the selected word.
// Optional build macro: MUX4_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module mux4_arb_ctrl
    import mux4_arb_pkg::*;
#(
    parameter int unsigned DW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mux4_arb_ctrl_if.master  bus
);

    state_t           state, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             en_q, en_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] last_winner, last_winner_d;

    logic [SEL_W-1:0] win_idx_c;
    logic             any_req_c;

    mux4_rr_pick u_pick (
        .req         (bus.req),
        .last_winner (last_winner),
        .win_idx     (win_idx_c),
        .any_req     (any_req_c)
    );

    // State and registered outputs; last_winner resets to 3 so source 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel_q       <= '0;
            en_q        <= 1'b0;
            gnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            last_winner <= SEL_W'(NREQ - 1);
        end else begin
            state       <= state_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            gnt_q       <= gnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            last_winner <= last_winner_d;
        end
    end

    // Next state; en/gnt are produced only on the transition into SEL, giving one-cycle pulses.
    always_comb begin
        state_d       = state;
        sel_d         = sel_q;
        en_d          = 1'b0;
        gnt_d         = '0;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        last_winner_d = last_winner;

        case (state)
            IDLE: begin
                if (any_req_c) begin
                    state_d       = SEL;
                    sel_d         = win_idx_c;
                    en_d          = 1'b1;
                    gnt_d         = sel_onehot(win_idx_c);
                    last_winner_d = win_idx_c;
                end
            end
            SEL: begin
                out_data_d  = bus.mux_in;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (any_req_c) begin
                        state_d       = SEL;
                        sel_d         = win_idx_c;
                        en_d          = 1'b1;
                        gnt_d         = sel_onehot(win_idx_c);
                        last_winner_d = win_idx_c;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.sel       = sel_q;
    assign bus.en        = en_q;
    assign bus.gnt       = gnt_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux4_arb_ctrl.sv
// Self-checking bench for mux4_arb_ctrl with a behavioural 4:1 mux and a grant/data scoreboard.
module tb_mux4_arb_ctrl;
    import mux4_arb_pkg::*;

    localparam int unsigned DW = 4;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic [DW-1:0]   data;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [DW-1:0] src_data [NREQ];

    exp_t          exp_q [$];
    logic [DW-1:0] data_q [$];

    int checks   = 0;
    int failures = 0;

    mux4_arb_ctrl_if #(.DW(DW)) bus ();

    mux4_arb_ctrl #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Downstream mux: output only meaningful while en is high.
    assign bus.mux_in = bus.en ? src_data[bus.sel] : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req       = 4'b1010;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
        checks++; if (bus.sel !== 2'b00) begin failures++; $display("FAIL reset_sel got=%b exp=00", bus.sel); end
        checks++; if (bus.en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", bus.en); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 4'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
        checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=IDLE", dut.state); end
        checks++; if (dut.last_winner !== 2'd3) begin failures++; $display("FAIL reset_last_winner got=%0d exp=3", dut.last_winner); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL first_grant_lowest got=%b exp=0010", bus.gnt); end
        bus.req = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_basic_latency();
        logic [DW-1:0] d;
        apply_reset();
        src_data[2] = 4'hA;
        bus.req = 4'b0100;
        data_q.push_back(4'hA);
        @(negedge clk);
        checks++; if (bus.sel !== 2'b10) begin failures++; $display("FAIL basic_sel got=%b exp=10", bus.sel); end
        checks++; if (bus.en !== 1'b1) begin failures++; $display("FAIL basic_en got=%b exp=1", bus.en); end
        checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL basic_gnt got=%b exp=0100", bus.gnt); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", bus.out_valid); end
        bus.req = '0;
        @(negedge clk);
        d = data_q.pop_front();
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_data !== d) begin failures++; $display("FAIL basic_data got=%h exp=%h", bus.out_data, d); end
        checks++; if (bus.en !== 1'b0 || bus.gnt !== 4'b0000) begin failures++; $display("FAIL basic_pulse en=%b gnt=%b exp=0/0000", bus.en, bus.gnt); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_consume got=%b exp=0", bus.out_valid); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_rr_rotate();
        exp_t          e;
        logic [DW-1:0] d;
        int            last_cyc = -1;
        int            ngnt = 0;
        int            ndata = 0;
        logic [NREQ-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        for (int i = 0; i < NREQ; i++) src_data[i] = DW'(i + 5);
        exp_q.delete();
        data_q.delete();
        for (int i = 0; i < 5; i++) begin
`ifdef MUX4_ARB_FIXED_PRIO_EN
            e.gnt  = 4'b0001;
            e.data = src_data[0];
`else
            e.gnt  = seq[i];
            e.data = src_data[i % 4];
`endif
            exp_q.push_back(e);
        end
        bus.out_ready = 1'b1;
        bus.req       = 4'b1111;
        for (int cyc = 0; cyc < 60 && ndata < 5; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                checks++;
                if (data_q.size() == 0) begin
                    failures++; $display("FAIL rr_unexpected_word got=%h exp=none", bus.out_data);
                end else begin
                    d = data_q.pop_front();
                    if (bus.out_data !== d) begin failures++; $display("FAIL rr_data got=%h exp=%h", bus.out_data, d); end
                end
                ndata++;
            end
            if (bus.gnt !== 4'b0000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rr_unexpected_gnt got=%b exp=none", bus.gnt);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.gnt !== e.gnt) begin failures++; $display("FAIL rr_gnt got=%b exp=%b", bus.gnt, e.gnt); end
                    data_q.push_back(e.data);
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (cyc - last_cyc != 2) begin failures++; $display("FAIL rr_spacing got=%0d exp=2", cyc - last_cyc); end
                end
                last_cyc = cyc;
                ngnt++;
                if (ngnt == 5) bus.req = '0;
            end
        end
        checks++;
        if (ndata != 5 || exp_q.size() != 0) begin
            failures++; $display("FAIL rr_complete got=%0d words exp=5", ndata);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_hold_stall();
        apply_reset();
        src_data[1] = 4'h3;
        bus.req = 4'b0010;
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h3) begin failures++; $display("FAIL hold_capture valid=%b data=%h exp=1/3", bus.out_valid, bus.out_data); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_data !== 4'h3 || bus.sel !== 2'b01 || bus.en !== 1'b0 ||
                bus.gnt !== 4'b0000 || bus.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL hold_stable data=%h sel=%b en=%b gnt=%b valid=%b exp=3/01/0/0000/1",
                         bus.out_data, bus.sel, bus.en, bus.gnt, bus.out_valid);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL hold_release got=%b exp=0", bus.out_valid); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        exp_t          e;
        logic [DW-1:0] d;
        int            ngnt = 0;
        int            ndata = 0;
        apply_reset();
        for (int i = 0; i < NREQ; i++) src_data[i] = DW'(12 - i);
        exp_q.delete();
        data_q.delete();
        e.gnt = 4'b1000; e.data = src_data[3]; exp_q.push_back(e);
`ifdef MUX4_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 3; i++) begin e.gnt = 4'b0001; e.data = src_data[0]; exp_q.push_back(e); end
`else
        e.gnt = 4'b0001; e.data = src_data[0]; exp_q.push_back(e);
        e.gnt = 4'b1000; e.data = src_data[3]; exp_q.push_back(e);
        e.gnt = 4'b0001; e.data = src_data[0]; exp_q.push_back(e);
`endif
        bus.out_ready = 1'b1;
        bus.req       = 4'b1000;
        for (int cyc = 0; cyc < 60 && ndata < 4; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                checks++;
                if (data_q.size() == 0) begin
                    failures++; $display("FAIL wrap_unexpected_word got=%h exp=none", bus.out_data);
                end else begin
                    d = data_q.pop_front();
                    if (bus.out_data !== d) begin failures++; $display("FAIL wrap_data got=%h exp=%h", bus.out_data, d); end
                end
                ndata++;
            end
            if (bus.gnt !== 4'b0000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL wrap_unexpected_gnt got=%b exp=none", bus.gnt);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.gnt !== e.gnt) begin failures++; $display("FAIL wrap_gnt got=%b exp=%b", bus.gnt, e.gnt); end
                    data_q.push_back(e.data);
                end
                ngnt++;
                if (ngnt == 1) bus.req = 4'b1001;
                if (ngnt == 4) bus.req = '0;
            end
        end
        checks++;
        if (ndata != 4 || exp_q.size() != 0) begin
            failures++; $display("FAIL wrap_complete got=%0d words exp=4", ndata);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        src_data[0] = 4'h9;
        bus.req = 4'b0001;
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL midrst_setup got=%b exp=1", bus.out_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.en !== 1'b0 || bus.gnt !== 4'b0000 ||
            bus.out_data !== 4'h0 || bus.sel !== 2'b00 || dut.state !== IDLE) begin
            failures++;
            $display("FAIL midrst_async valid=%b en=%b gnt=%b data=%h sel=%b state=%0d exp=0/0/0000/0/00/IDLE",
                     bus.out_valid, bus.en, bus.gnt, bus.out_data, bus.sel, dut.state);
        end
        bus.req = 4'b1000;
        src_data[3] = 4'h6;
        @(negedge clk);
        checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL midrst_no_gnt got=%b exp=0000", bus.gnt); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.gnt !== 4'b1000) begin failures++; $display("FAIL midrst_gnt got=%b exp=1000", bus.gnt); end
        bus.req = '0;
        @(negedge clk);
        checks++; if (bus.out_data !== 4'h6) begin failures++; $display("FAIL midrst_data got=%h exp=6", bus.out_data); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_req_drop();
        apply_reset();
        src_data[0] = 4'h7;
        bus.req = 4'b0001;
        @(negedge clk);
        checks++; if (bus.gnt !== 4'b0001 || bus.en !== 1'b1) begin failures++; $display("FAIL drop_grant gnt=%b en=%b exp=0001/1", bus.gnt, bus.en); end
        bus.req = '0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h7) begin failures++; $display("FAIL drop_capture valid=%b data=%h exp=1/7", bus.out_valid, bus.out_data); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || dut.state !== IDLE || bus.en !== 1'b0) begin
            failures++; $display("FAIL drop_idle valid=%b state=%0d en=%b exp=0/IDLE/0", bus.out_valid, dut.state, bus.en);
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) src_data[i] = '0;
        test_reset();
        test_basic_latency();
        test_rr_rotate();
        test_hold_stall();
        test_wrap();
        test_reset_mid();
        test_req_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
